spi_mem_arbiter: RTL

Arbitrates the single serial memory port between two requesters: the control unit's instruction fetch (ROM, addressed by PC) and data accesses (RAM read/write, addressed by {mpage, mar}). It sits between the requesters and the SPI engine. It drives the engine's start, write, address and data inputs, steers the engine's chip-select onto the ROM or RAM select pin, captures read data, and aborts transactions that exceed a watchdog limit.

---
 rtl/jrb8_mem_pkg.sv | 19 +
 rtl/spi_mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/jrb8_mem_pkg.sv
// Shared types for the serial memory port: arbiter states, port owner and
// the default watchdog limit.
package jrb8_mem_pkg;

   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd2048;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DATA,
      DONE
   } mem_state_t;

   typedef enum logic {
      OWN_FETCH,
      OWN_DATA
   } mem_owner_t;

endpackage

// File: rtl/spi_mem_arbiter.sv
// Two-way round-robin arbiter for the single SPI memory port (instruction fetch
// from ROM vs. data RAM access), with chip-select steering and a watchdog abort.
module spi_mem_arbiter
   import jrb8_mem_pkg::*;
#(
   parameter int          ADDR_W  = 16,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_done,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [7:0]        data_wdata,
   output logic              data_gnt,
   output logic              data_done,
   output logic [7:0]        rdata,
   output logic              err,
   output logic              spi_start,
   output logic              spi_write,
   output logic [ADDR_W-1:0] spi_address,
   output logic [7:0]        spi_wdata,
   input  logic              spi_done,
   input  logic [7:0]        spi_rdata,
   input  logic              spi_cs,
   output logic              cs_rom,
   output logic              cs_ram
);

   mem_state_t        state;
   mem_owner_t        last_owner;
   logic [15:0]       wdog;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [7:0]        wdata_q;

   // On a tie the requester that was not served last wins.
   function automatic mem_owner_t pick(input logic f, input logic d, input mem_owner_t last);
      if (f && d)
         return (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      else if (d)
         return OWN_DATA;
      else
         return OWN_FETCH;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= OWN_FETCH;
         wdog       <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         fetch_gnt  <= 1'b0;
         data_gnt   <= 1'b0;
         fetch_done <= 1'b0;
         data_done  <= 1'b0;
         err        <= 1'b0;
         spi_start  <= 1'b0;
         rdata      <= '0;
      end else begin
         fetch_done <= 1'b0;
         data_done  <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (fetch_req || data_req) begin
                  wdog      <= '0;
                  spi_start <= 1'b1;
                  if (pick(fetch_req, data_req, last_owner) == OWN_DATA) begin
                     state    <= DATA;
                     data_gnt <= 1'b1;
                     addr_q   <= data_addr;
                     we_q     <= data_we;
                     wdata_q  <= data_wdata;
                  end else begin
                     state     <= FETCH;
                     fetch_gnt <= 1'b1;
                     addr_q    <= fetch_addr;
                     we_q      <= 1'b0;
                     wdata_q   <= '0;
                  end
               end
            end
            FETCH, DATA: begin
               wdog <= wdog + 16'd1;
               // A completion on the last watchdog cycle still counts as success.
               if (spi_done || (wdog == TIMEOUT - 16'd1)) begin
                  if (spi_done && !(state == DATA && we_q))
                     rdata <= spi_rdata;
                  err        <= !spi_done;
                  fetch_done <= (state == FETCH);
                  data_done  <= (state == DATA);
                  spi_start  <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               last_owner <= data_gnt ? OWN_DATA : OWN_FETCH;
               fetch_gnt  <= 1'b0;
               data_gnt   <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      spi_address = '0;
      spi_wdata   = '0;
      spi_write   = 1'b0;
      if (state != IDLE) begin
         spi_address = addr_q;
         spi_wdata   = wdata_q;
         spi_write   = (state == DATA) && we_q;
      end
   end

   // Chip-select follows the engine only toward the current owner's device.
   assign cs_rom = (state == FETCH) ? spi_cs : 1'b1;
   assign cs_ram = (state == DATA)  ? spi_cs : 1'b1;

endmodule
